// File: rtl/cross_bar_slave_sched_if.sv
// cross_bar_slave_sched_if: master-side and slave-side handshake bundle for one slave-port scheduler
interface cross_bar_slave_sched_if #(
  parameter int MASTER_N = 4,
  parameter int RD_DEPTH = 4
);
  localparam int IDX_W = MASTER_N > 1 ? $clog2(MASTER_N) : 1;
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;
  logic [MASTER_N-1:0] m_req;
  logic [MASTER_N-1:0] m_cmd;
  logic [MASTER_N-1:0] m_ack;
  logic [MASTER_N-1:0] m_resp;
  logic [IDX_W-1:0]    sel_master;
  logic [IDX_W-1:0]    resp_master;
  logic                s_req;
  logic                s_cmd;
  logic                s_ack;
  logic                s_resp;
  logic [CNT_W-1:0]    rd_outstanding;
  logic                err_unexp_resp;
  modport slave (
    input  m_req, m_cmd, s_ack, s_resp,
    output m_ack, sel_master, s_req, s_cmd, m_resp, resp_master, rd_outstanding, err_unexp_resp
  );
  modport master (
    output m_req, m_cmd, s_ack, s_resp,
    input  m_ack, sel_master, s_req, s_cmd, m_resp, resp_master, rd_outstanding, err_unexp_resp
  );
endinterface

// File: rtl/cross_bar_slave_sched.sv
// cross_bar_slave_sched: round-robin grant of one slave port plus in-order read-response routing
module cross_bar_slave_sched #(
  parameter int MASTER_N = 4,
  parameter int RD_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  cross_bar_slave_sched_if.slave   bus
);
  localparam int IDX_W = MASTER_N > 1 ? $clog2(MASTER_N) : 1;
  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RD_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MASTER_N - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, sel_q, sel_d, last_q, last_d;
  logic [IDX_W-1:0]    fifo_q [RD_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [MASTER_N-1:0] elig;
  logic [IDX_W-1:0]    pick, cand, head;
  logic                found, accept, push, pop, empty;
  assign empty  = cnt_q == '0;
  assign head   = fifo_q[rd_q];
  assign accept = state_q == BUSY && bus.s_ack;
  assign push   = accept && !bus.m_cmd[sel_q];
  assign pop    = bus.s_resp && !empty;
  // occupancy never exceeds FULL, so "not full" is the same as "below RD_DEPTH"
  assign elig   = bus.m_req & (bus.m_cmd | {MASTER_N{cnt_q != FULL}});
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int k = 0; k < MASTER_N; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % MASTER_N);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    state_d = accept ? IDLE : (state_q == IDLE && found) ? BUSY : state_q;
    sel_d   = (state_q == IDLE && found) ? pick : sel_q;
    ptr_d   = accept ? ((sel_q == LAST) ? '0 : sel_q + 1'b1) : ptr_q;
  end
  always_comb begin
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_d  = err_q | (bus.s_resp & empty);
    last_d = pop ? head : last_q;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // storage needs no reset: entries are only read while occupancy says they are valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= sel_q;
  end
  assign bus.m_ack          = accept ? MASTER_N'(1) << sel_q : '0;
  assign bus.sel_master     = sel_q;
  assign bus.s_req          = state_q == BUSY;
  assign bus.s_cmd          = state_q == BUSY && bus.m_cmd[sel_q];
  assign bus.m_resp         = pop ? MASTER_N'(1) << head : '0;
  assign bus.resp_master    = pop ? head : last_q;
  assign bus.rd_outstanding = cnt_q;
  assign bus.err_unexp_resp = err_q;
endmodule

// File: tb/tb_cross_bar_slave_sched.sv
// tb_cross_bar_slave_sched: directed and randomized checks of the slave-port scheduler
module tb_cross_bar_slave_sched;
  localparam int N  = 4;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;
  cross_bar_slave_sched_if #(.MASTER_N(N), .RD_DEPTH(RD)) bus ();
  cross_bar_slave_sched #(.MASTER_N(N), .RD_DEPTH(RD)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));
  int vec_n = 0;
  int miss_n = 0;
  bit mbusy, merr;
  int mgnt, mptr, mlast;
  int q[$];
  logic [17:0] exp_vec, got_vec;
  logic [3:0]  g_ack, g_resp;
  logic [1:0]  g_sel;
  logic [2:0]  g_rdo;
  logic        g_sreq, g_err;

  function automatic void model_reset();
    mbusy = 0; merr = 0; mgnt = 0; mptr = 0; mlast = 0;
    q.delete();
  endfunction

  function automatic logic [17:0] model_eval();
    logic [3:0] ack, rsp;
    logic [1:0] rm;
    logic       scmd;
    ack  = (mbusy && bus.s_ack) ? 4'(1 << mgnt) : 4'b0;
    rsp  = (bus.s_resp && q.size() > 0) ? 4'(1 << q[0]) : 4'b0;
    rm   = (bus.s_resp && q.size() > 0) ? 2'(q[0]) : 2'(mlast);
    scmd = mbusy ? bus.m_cmd[mgnt] : 1'b0;
    return {ack, 2'(mgnt), mbusy, scmd, rsp, rm, 3'(q.size()), merr};
  endfunction

  function automatic void model_tick();
    int g = -1;
    int occ = q.size();
    if (!mbusy)
      for (int k = 0; k < N; k++) begin
        int j = (mptr + k) % N;
        if (g < 0 && bus.m_req[j] && (bus.m_cmd[j] || occ < RD)) g = j;
      end
    if (bus.s_resp) begin
      if (occ > 0) mlast = q.pop_front();
      else merr = 1;
    end
    if (mbusy && bus.s_ack) begin
      if (!bus.m_cmd[mgnt]) q.push_back(mgnt);
      mptr = (mgnt + 1) % N;
      mbusy = 0;
    end else if (g >= 0) begin
      mgnt = g;
      mbusy = 1;
    end
  endfunction

  task automatic advance();
    @(negedge clk);
    exp_vec = model_eval();
    got_vec = {bus.m_ack, bus.sel_master, bus.s_req, bus.s_cmd, bus.m_resp, bus.resp_master, bus.rd_outstanding, bus.err_unexp_resp};
    {g_ack, g_sel, g_sreq, g_resp, g_rdo, g_err} = {bus.m_ack, bus.sel_master, bus.s_req, bus.m_resp, bus.rd_outstanding, bus.err_unexp_resp};
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.m_req = '0; bus.m_cmd = '0; bus.s_ack = 1'b0; bus.s_resp = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(int idx);
    bit seen = 0;
    bus.m_req = 4'(1 << idx); bus.m_cmd = '0; bus.s_ack = 1'b1;
    for (int c = 0; c < 4 && !seen; c++) begin
      advance(); vec_n++;
      if (got_vec !== exp_vec) begin miss_n++; $display("FAIL issue_read%0d got %h exp %h", idx, got_vec, exp_vec); end
      seen = g_ack != 0;
    end
    vec_n++;
    if (!seen) begin miss_n++; $display("FAIL issue_read%0d_timeout got no m_ack exp ack within 4 cycles", idx); end
    bus.m_req = '0; bus.s_ack = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.m_req = 4'($urandom); bus.m_cmd = 4'($urandom); bus.s_ack = 1'b1; bus.s_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got_vec = {bus.m_ack, bus.sel_master, bus.s_req, bus.s_cmd, bus.m_resp, bus.resp_master, bus.rd_outstanding, bus.err_unexp_resp};
    vec_n++;
    if (got_vec !== 18'h0) begin miss_n++; $display("FAIL reset_hold got %h exp 0", got_vec); end
    do_reset();
    advance(); vec_n++;
    if (got_vec !== 18'h0 || got_vec !== exp_vec) begin miss_n++; $display("FAIL reset_release got %h exp %h", got_vec, exp_vec); end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m_req = 4'b0001; bus.m_cmd = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      advance(); vec_n++;
      if (got_vec !== exp_vec) begin miss_n++; $display("FAIL single_wait c%0d got %h exp %h", c, got_vec, exp_vec); end
    end
    bus.s_ack = 1'b1;
    advance(); vec_n++;
    if (g_ack !== 4'b0001 || g_sel !== 2'd0 || got_vec !== exp_vec) begin miss_n++; $display("FAIL single_ack got ack %b sel %0d exp ack 0001 sel 0", g_ack, g_sel); end
    bus.m_req = '0; bus.s_ack = 1'b0;
    advance(); vec_n++;
    if (g_rdo !== 3'd1 || got_vec !== exp_vec) begin miss_n++; $display("FAIL single_outstanding got %0d exp 1", g_rdo); end
    bus.s_resp = 1'b1;
    advance(); vec_n++;
    if (g_resp !== 4'b0001 || got_vec !== exp_vec) begin miss_n++; $display("FAIL single_resp got %b exp 0001", g_resp); end
    bus.s_resp = 1'b0;
    advance(); vec_n++;
    if (g_rdo !== 3'd0 || got_vec !== exp_vec) begin miss_n++; $display("FAIL single_drain got %0d exp 0", g_rdo); end
  endtask

  task automatic test_rr_writes();
    int order[$];
    do_reset();
    bus.m_req = 4'b1111; bus.m_cmd = 4'b1111; bus.s_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      advance(); vec_n++;
      if (got_vec !== exp_vec) begin miss_n++; $display("FAIL rr_cycle c%0d got %h exp %h", c, got_vec, exp_vec); end
      if (g_ack != 0) begin
        order.push_back($clog2(g_ack));
        vec_n++;
        if (c % 2 != 1) begin miss_n++; $display("FAIL rr_spacing got ack at cycle %0d exp odd cycle", c); end
      end
    end
    bus.m_req = '0; bus.m_cmd = '0; bus.s_ack = 1'b0;
    vec_n++;
    if (order.size() != 5) begin miss_n++; $display("FAIL rr_count got %0d acks exp 5", order.size()); end
    for (int i = 0; i < order.size() && i < 5; i++) begin
      vec_n++;
      if (order[i] != i % 4) begin miss_n++; $display("FAIL rr_order idx%0d got %0d exp %0d", i, order[i], i % 4); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.m_req = 4'b0100; bus.m_cmd = 4'b0100; bus.s_ack = 1'b0;
    advance(); vec_n++;
    if (got_vec !== exp_vec) begin miss_n++; $display("FAIL hold_grant got %h exp %h", got_vec, exp_vec); end
    bus.m_req = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      advance(); vec_n++;
      if (g_sel !== 2'd2 || g_sreq !== 1'b1 || got_vec !== exp_vec) begin miss_n++; $display("FAIL hold_frozen c%0d got sel %0d s_req %b exp sel 2 s_req 1", c, g_sel, g_sreq); end
    end
    bus.s_ack = 1'b1;
    advance(); vec_n++;
    if (g_ack !== 4'b0100 || got_vec !== exp_vec) begin miss_n++; $display("FAIL hold_ack got %b exp 0100", g_ack); end
    bus.s_ack = 1'b0; bus.m_req = 4'b0001;
    advance();
    advance(); vec_n++;
    if (g_sel !== 2'd0 || g_sreq !== 1'b1 || got_vec !== exp_vec) begin miss_n++; $display("FAIL hold_next got sel %0d exp 0", g_sel); end
  endtask

  task automatic test_full();
    bit seen;
    int exp_order[4] = '{3, 0, 2, 1};
    do_reset();
    issue_read(1); issue_read(3); issue_read(0); issue_read(2);
    advance(); vec_n++;
    if (g_rdo !== 3'd4 || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_level got %0d exp 4", g_rdo); end
    bus.m_req = 4'b1010; bus.m_cmd = 4'b1000; bus.s_ack = 1'b1;
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      advance(); seen = g_ack != 0;
    end
    vec_n++;
    if (g_ack !== 4'b1000 || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_write got ack %b exp 1000", g_ack); end
    bus.m_req = 4'b0010; bus.m_cmd = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      advance(); vec_n++;
      if (g_sreq !== 1'b0 || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_blocked c%0d got s_req %b exp 0", c, g_sreq); end
    end
    bus.s_resp = 1'b1;
    advance(); vec_n++;
    if (g_resp !== 4'b0010 || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_first_resp got %b exp 0010", g_resp); end
    bus.s_resp = 1'b0;
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      advance(); seen = g_ack != 0;
    end
    vec_n++;
    if (g_ack !== 4'b0010 || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_unblock got ack %b exp 0010", g_ack); end
    bus.m_req = '0; bus.s_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_resp = 1'b1;
      advance(); vec_n++;
      if (g_resp !== 4'(1 << exp_order[i]) || got_vec !== exp_vec) begin miss_n++; $display("FAIL full_resp%0d got %b exp master %0d", i, g_resp, exp_order[i]); end
      bus.s_resp = 1'b0;
      advance();
    end
    vec_n++;
    if (g_rdo !== 3'd0) begin miss_n++; $display("FAIL full_drain got %0d exp 0", g_rdo); end
  endtask

  task automatic test_unexp_resp();
    do_reset();
    bus.s_resp = 1'b1;
    advance(); vec_n++;
    if (g_resp !== 4'b0000 || got_vec !== exp_vec) begin miss_n++; $display("FAIL unexp_route got %b exp 0000", g_resp); end
    bus.s_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      advance(); vec_n++;
      if (g_err !== 1'b1 || got_vec !== exp_vec) begin miss_n++; $display("FAIL unexp_sticky c%0d got %b exp 1", c, g_err); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_read(0); issue_read(1);
    bus.m_req = 4'b0100; bus.m_cmd = 4'b0100; bus.s_ack = 1'b0;
    advance();
    advance(); vec_n++;
    if (g_sreq !== 1'b1 || g_rdo !== 3'd2) begin miss_n++; $display("FAIL mid_setup got s_req %b rd %0d exp 1 2", g_sreq, g_rdo); end
    aresetn = 1'b0;
    #2;
    got_vec = {bus.m_ack, bus.sel_master, bus.s_req, bus.s_cmd, bus.m_resp, bus.resp_master, bus.rd_outstanding, bus.err_unexp_resp};
    vec_n++;
    if (got_vec !== 18'h0) begin miss_n++; $display("FAIL mid_async got %h exp 0", got_vec); end
    model_reset();
    bus.m_req = '0; bus.m_cmd = '0;
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    bus.s_resp = 1'b1;
    advance(); vec_n++;
    if (g_resp !== 4'b0000 || got_vec !== exp_vec) begin miss_n++; $display("FAIL mid_late_resp got %b exp 0000", g_resp); end
    bus.s_resp = 1'b0;
    bus.m_req = 4'b1111; bus.m_cmd = 4'b1111; bus.s_ack = 1'b1;
    advance(); vec_n++;
    if (g_err !== 1'b1 || got_vec !== exp_vec) begin miss_n++; $display("FAIL mid_err got %b exp 1", g_err); end
    advance(); vec_n++;
    if (g_ack !== 4'b0001 || got_vec !== exp_vec) begin miss_n++; $display("FAIL mid_first_grant got %b exp 0001", g_ack); end
  endtask

  task automatic test_random();
    logic [3:0] r, c;
    r = '0; c = '0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int m = 0; m < N; m++)
        if (!r[m] && $urandom_range(3) == 0) begin r[m] = 1'b1; c[m] = 1'($urandom_range(1)); end
      bus.m_req = r; bus.m_cmd = c;
      bus.s_ack = 1'($urandom_range(1));
      bus.s_resp = q.size() > 0 ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      advance(); vec_n++;
      if (got_vec !== exp_vec) begin miss_n++; $display("FAIL random i%0d got %h exp %h", i, got_vec, exp_vec); end
      r = r & ~exp_vec[17:14];
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_writes();
    test_hold();
    test_full();
    test_unexp_resp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule

// File: doc/cross_bar_slave_sched.md
Name: cross_bar_slave_sched

Overview:
Per-slave-port scheduler for the cross bar. It arbitrates among MASTER_N masters targeting one slave using round-robin priority. It holds the grant for the whole request handshake and drives the request/address mux select. It tracks outstanding reads in an in-order ID FIFO so each read response is routed back to the master that issued it. One instance sits in front of each slave port; the datapath muxes are driven from sel_master and resp_master.

Parameters:
MASTER_N, 4, number of masters (from cross_bar_pkg)
RD_DEPTH, 4, max outstanding reads per slave, power of two, ≥2
IDX_W, $clog2(MASTER_N), master index width (derived, not overridable)

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
m_req  in  MASTER_N  per-master request targeting this slave
m_cmd  in  MASTER_N  per-master command, 1=write, 0=read
m_ack  out  MASTER_N  one-hot accept pulse to the granted master
sel_master  out  IDX_W  index of granted master, selects addr/wdata/cmd mux
s_req  out  1  request to slave
s_cmd  out  1  command to slave
s_ack  in  1  slave accepts request
s_resp  in  1  slave read-response valid, one-cycle pulse
m_resp  out  MASTER_N  one-hot read-response valid routed to the issuing master
resp_master  out  IDX_W  index of master owning current response, selects rdata demux
rd_outstanding  out  $clog2(RD_DEPTH)+1  current FIFO occupancy
err_unexp_resp  out  1  sticky: s_resp seen with FIFO empty

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr pointer=0, FIFO empty. Outputs: m_ack=0, s_req=0, s_cmd=0, sel_master=0, m_resp=0, resp_master=0, rd_outstanding=0, err_unexp_resp=0.
- Reset mid-transaction aborts everything. Responses arriving after reset release hit an empty FIFO, so they set err_unexp_resp.
- Eligibility: master i is eligible when m_req[i] && (m_cmd[i] || rd_outstanding < RD_DEPTH).
- FSM IDLE: if any master is eligible, pick the first eligible index searching pointer, pointer+1, … modulo MASTER_N. Register it into sel_master and go to BUSY. s_req=0 in IDLE.
- FSM BUSY: s_req=1 and s_cmd=m_cmd[sel_master]. sel_master and grant stay frozen until s_ack, regardless of changes in other masters' m_req.
- Accept cycle (BUSY && s_ack): m_ack[sel_master]=1 combinationally in this cycle. Pointer becomes (sel_master+1) mod MASTER_N. If it is a read, push sel_master into the FIFO. Next state is IDLE.
- Latency: m_req to s_req is 1 cycle. Minimum spacing between accepts is 2 cycles (one IDLE cycle per transaction).
- Protocol: a master holds m_req/m_cmd/addr/wdata stable until its m_ack. Behaviour is undefined if a granted master drops m_req before m_ack; the scheduler keeps s_req asserted.
- Response path: on s_resp with FIFO non-empty, m_resp[head]=1 and resp_master=head in the same cycle (combinational from the FIFO head), then pop. On s_resp with FIFO empty, m_resp stays 0 and err_unexp_resp sets; only reset clears it.
- Simultaneous push and pop: occupancy unchanged, both operations take effect.
- Full: reads are ineligible; writes still arbitrate normally. Overflow cannot occur because eligibility is checked at grant and only one grant is in flight.
- FIFO pointers wrap modulo RD_DEPTH. rd_outstanding ranges 0..RD_DEPTH.
- resp_master holds the last head value while idle. Downstream qualifies it with m_resp.

Test Plan:
- After reset, m_req=4'b0001 read, s_ack returned 2 cycles after s_req → sel_master=0, m_ack=4'b0001 for one cycle, rd_outstanding=1. Then s_resp → m_resp=4'b0001, rd_outstanding=0.
- m_req=4'b1111 held, all writes, s_ack=1 constant → grant order 0,1,2,3,0, with an m_ack pulse every 2 cycles.
- Grant to master 2, s_ack held low 5 cycles while m_req[0] rises → sel_master stays 2 and s_req stays 1. After ack, master 3 is granted if requesting, else master 0.
- Four reads from masters 1,3,0,2 accepted, then fifth read from master 1 plus a write from master 3 → read blocked, write granted. One s_resp routes to master 1 and unblocks the read. Responses come back in order 1,3,0,2.
- s_resp when rd_outstanding=0 → m_resp=0, err_unexp_resp=1 and stays 1 until aresetn low.
- aresetn pulsed low while in BUSY with 2 reads outstanding → all outputs go to reset values immediately, pointer=0, and the next grant starts from master 0.
